// File: rtl/arm_mul_unit.sv
// Iterative shift-and-add multiplier for MUL/MLA/UMULL/SMULL, retiring STEP multiplier bits per cycle.
// Results and {N,Z} flags are registered on DONE entry and held until the next completed operation.
module arm_mul_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       flags
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MLA   = 2'b01;
    localparam logic [1:0] OP_UMULL = 2'b10;
    localparam logic [1:0] OP_SMULL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic [1:0]      op_reg;
    logic            neg_reg;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]   prod;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    step_sum;
    logic [PW-1:0]    prod_next;
    logic [PW-1:0]    final_prod;
    logic [WIDTH-1:0] final_lo;
    logic [WIDTH-1:0] final_hi;
    logic [1:0]       flags_next;
    logic             long_op;

    // SMULL works on magnitudes; the most-negative value maps to itself, which is correct as an unsigned W-bit magnitude.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (op == OP_SMULL) begin
            if (a[WIDTH-1]) a_mag = -a;
            if (b[WIDTH-1]) b_mag = -b;
        end
    end

    always_comb begin
        step_sum = '0;
        for (int i = 0; i < STEP; i++) begin
            if (mplier[i]) step_sum = step_sum + (mcand << i);
        end
    end

    always_comb begin
        long_op    = op_reg[1];
        prod_next  = prod + step_sum;
        final_prod = neg_reg ? -prod_next : prod_next;
        final_lo   = final_prod[WIDTH-1:0];
        final_hi   = long_op ? final_prod[PW-1:WIDTH] : '0;
        if (long_op) flags_next = {final_hi[WIDTH-1], (final_prod == '0)};
        else         flags_next = {final_lo[WIDTH-1], (final_lo == '0)};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            counter   <= '0;
            op_reg    <= OP_MUL;
            neg_reg   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            flags     <= 2'b00;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        counter <= '0;
                        op_reg  <= op;
                        neg_reg <= (op == OP_SMULL) && (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand   <= {{WIDTH{1'b0}}, a_mag};
                        mplier  <= b_mag;
                        prod    <= (op == OP_MLA) ? {{WIDTH{1'b0}}, acc} : '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    prod   <= prod_next;
                    mcand  <= mcand << STEP;
                    mplier <= mplier >> STEP;
                    if (counter == CW'(N - 1)) begin
                        state     <= S_DONE;
                        counter   <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result_lo <= final_lo;
                        result_hi <= final_hi;
                        flags     <= flags_next;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_mul_unit.sv
// Directed bench for arm_mul_unit: a STEP=1 and a STEP=4 instance share the clock and operand buses.
// Inputs are driven and outputs sampled on the falling edge.
module tb_arm_mul_unit;

    logic        clk;
    logic        reset;
    logic        start1;
    logic        start4;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;

    logic        busy1, done1, busy4, done4;
    logic [31:0] lo1, hi1, lo4, hi4;
    logic [1:0]  flags1, flags4;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_cnt;
    int done_seen;

    arm_mul_unit #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b), .acc(acc),
        .busy(busy1), .done(done1), .result_lo(lo1), .result_hi(hi1), .flags(flags1)
    );

    arm_mul_unit #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b), .acc(acc),
        .busy(busy4), .done(done4), .result_lo(lo4), .result_hi(hi4), .flags(flags4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raises start in the current cycle and counts falling edges until done (bounded at 200).
    task automatic applyStimulus(input bit unit, input bit hold, input logic [1:0] o,
                                 input logic [31:0] av, input logic [31:0] bv, input logic [31:0] accv,
                                 output int latency, output int busy_cycles);
        op  = o;
        a   = av;
        b   = bv;
        acc = accv;
        if (unit) start4 = 1'b1;
        else      start1 = 1'b1;
        latency     = 0;
        busy_cycles = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            latency++;
            if (!hold) begin
                start1 = 1'b0;
                start4 = 1'b0;
            end
            if ((unit ? busy4 : busy1) === 1'b1) busy_cycles++;
            if ((unit ? done4 : done1) === 1'b1) break;
        end
    endtask

    initial begin
        reset  = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        acc    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {63'd0, busy1}, 64'd0);
        checkOutput("reset_done", {63'd0, done1}, 64'd0);
        checkOutput("reset_result", {hi1, lo1}, 64'd0);
        checkOutput("reset_flags", {62'd0, flags1}, 64'd0);
        checkOutput("reset_step4", {hi4, lo4, 30'd0, flags4}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'd7, 32'd6, 32'd0, lat, busy_cnt);
        checkOutput("mul_latency", lat, 64'd33);
        checkOutput("mul_busy_cycles", busy_cnt, 64'd32);
        checkOutput("mul_result", {hi1, lo1}, 64'd42);
        checkOutput("mul_flags", {62'd0, flags1}, 64'd0);
        @(negedge clk);
        checkOutput("done_one_pulse", {63'd0, done1}, 64'd0);
        checkOutput("idle_hold_result", {hi1, lo1}, 64'd42);

        applyStimulus(1'b0, 1'b0, 2'b01, 32'd3, 32'd5, 32'd100, lat, busy_cnt);
        checkOutput("mla_result", {hi1, lo1}, 64'd115);

        applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 32'h1234, 32'd0, lat, busy_cnt);
        checkOutput("mul_zero_result", {hi1, lo1}, 64'd0);
        checkOutput("mul_zero_flags", {62'd0, flags1}, 64'd1);

        applyStimulus(1'b0, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, lat, busy_cnt);
        checkOutput("umull_max_result", {hi1, lo1}, 64'hFFFF_FFFE_0000_0001);
        checkOutput("umull_max_flags", {62'd0, flags1}, 64'd2);

        applyStimulus(1'b0, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'd2, 32'd0, lat, busy_cnt);
        checkOutput("smull_neg_result", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("smull_neg_flags", {62'd0, flags1}, 64'd2);

        applyStimulus(1'b0, 1'b0, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, lat, busy_cnt);
        checkOutput("smull_minmin_result", {hi1, lo1}, 64'h4000_0000_0000_0000);
        checkOutput("smull_minmin_flags", {62'd0, flags1}, 64'd0);

        applyStimulus(1'b0, 1'b0, 2'b11, 32'h8000_0000, 32'd1, 32'd0, lat, busy_cnt);
        checkOutput("smull_min_one_result", {hi1, lo1}, 64'hFFFF_FFFF_8000_0000);

        applyStimulus(1'b0, 1'b0, 2'b11, 32'd5, 32'hFFFF_FFFD, 32'd0, lat, busy_cnt);
        checkOutput("smull_pos_neg_result", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFF1);

        // A start during RUN must be dropped; outputs keep the previous result until DONE.
        op     = 2'b00;
        a      = 32'd7;
        b      = 32'd6;
        start1 = 1'b1;
        lat    = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            lat++;
            start1 = 1'b0;
            if (lat == 5) begin
                op     = 2'b10;
                a      = 32'd100;
                b      = 32'd100;
                start1 = 1'b1;
            end
            if (lat == 10) checkOutput("run_holds_prev", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFF1);
            if (done1 === 1'b1) break;
        end
        start1 = 1'b0;
        checkOutput("midrun_start_latency", lat, 64'd33);
        checkOutput("midrun_start_result", {hi1, lo1}, 64'd42);
        @(negedge clk);
        checkOutput("midrun_start_not_queued", {62'd0, busy1, done1}, 64'd0);

        applyStimulus(1'b0, 1'b1, 2'b00, 32'd9, 32'd9, 32'd0, lat, busy_cnt);
        checkOutput("held_first_latency", lat, 64'd33);
        checkOutput("held_first_result", {hi1, lo1}, 64'd81);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'd10, 32'd10, 32'd0, lat, busy_cnt);
        checkOutput("held_second_latency", lat, 64'd33);
        checkOutput("held_second_result", {hi1, lo1}, 64'd100);

        // Abort with reset in the tenth RUN cycle.
        op     = 2'b00;
        a      = 32'd7;
        b      = 32'd6;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("abort_busy_before", {63'd0, busy1}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {63'd0, busy1}, 64'd0);
        checkOutput("abort_done", {63'd0, done1}, 64'd0);
        checkOutput("abort_result", {hi1, lo1}, 64'd0);
        checkOutput("abort_flags", {62'd0, flags1}, 64'd0);
        reset     = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1 === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 64'd0);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'd3, 32'd4, 32'd0, lat, busy_cnt);
        checkOutput("after_abort_latency", lat, 64'd33);
        checkOutput("after_abort_result", {hi1, lo1}, 64'd12);

        applyStimulus(1'b1, 1'b0, 2'b00, 32'd7, 32'd6, 32'd0, lat, busy_cnt);
        checkOutput("step4_latency", lat, 64'd9);
        checkOutput("step4_busy_cycles", busy_cnt, 64'd8);
        checkOutput("step4_result", {hi4, lo4}, 64'd42);
        applyStimulus(1'b1, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'd2, 32'd0, lat, busy_cnt);
        checkOutput("step4_smull_result", {hi4, lo4}, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("step4_smull_flags", {62'd0, flags4}, 64'd2);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, lat, busy_cnt);
        checkOutput("step4_umull_result", {hi4, lo4}, 64'h0B00_EA4E_242D_2080);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
